y86_alu: RTL and testbench
==========================

// Module: y86_alu
// PURPOSE
//  64-bit integer ALU for the Y86 pipeline EXECUTE stage. Computes AND, XOR, ADD and SUB.
//  Result r and overflow ofw are combinational, so execute consumes them in the same cycle.
//  Optional registered condition codes (ZF/SF/OF) feed cmovXX/jXX evaluation.
// PARAMETERS
//  WIDTH  64  operand/result width in bits (signed two's complement)
// PORTS
//  clk     in   1      clock (flag register only)
//  rst_n   in   1      asynchronous, active-low reset
//  select  in   3      op select: 000 AND, 001 XOR, 010 ADD, 011 SUB, 1xx reserved
//  p       in   WIDTH  signed operand A (valA)
//  q       in   WIDTH  signed operand B (valB)
//  set_cc  in   1      load condition codes from current result at the clk rising edge
//  r       out  WIDTH  signed result
//  ofw     out  1      signed overflow of the current operation
//  zf      out  1      registered zero flag
//  sf      out  1      registered sign flag
//  of      out  1      registered overflow flag
// BEHAVIOUR
//  - One clock, clk; reset is asynchronous and active-low (rst_n).
//  - r/ofw are purely combinational: zero latency, no dependence on clk or rst_n.
//  - AND: r = p & q, ofw = 0.
//  - XOR: r = p ^ q, ofw = 0.
//  - ADD: r = q + p (mod 2^WIDTH); ofw = (p[MSB]==q[MSB]) && (r[MSB]!=p[MSB]).
//  - SUB: r = q - p (Y86 subq: rB - rA); ofw = (p[MSB]!=q[MSB]) && (r[MSB]!=q[MSB]).
//  - Reserved select (1xx): r = 0, ofw = 0. No X propagation for any defined select.
//  - Carry-out is discarded; wrap-around is silent, e.g. 0x7FFF..F + 1 = 0x8000..0 with ofw = 1.
//  - Flag register, when set_cc = 1 at posedge clk:
//      zf <= (r == 0); sf <= r[MSB]; of <= ofw.
//    When set_cc = 0, the flags hold their value.
//  - rst_n low: zf, sf, of go to 0 immediately (asynchronous) and stay 0 while low.
//    Release is synchronous to the next clk edge; set_cc is ignored during reset.
//  - Simultaneous select/operand change and set_cc: the flags capture the values settled before the edge.
// CONFIGURATION
//  - ALU_CC_EN defined: flag register above is built and zf/sf/of are live.
//  - ALU_CC_EN undefined: no flag register; zf = sf = of = 0 constant; set_cc, clk and rst_n unused.
//    r/ofw are identical in both builds.
// STRUCTURE
//  - Package y86_alu_pkg: select encodings ALU_AND = 3'b000, ALU_XOR = 3'b001,
//    ALU_ADD = 3'b010, ALU_SUB = 3'b011; WIDTH default; flag index constants.
//  - One sub-module y86_alu_addsub: WIDTH-bit adder/subtractor with a sub input
//    (computes q + ~p + 1) producing sum and signed overflow.
//    Logic ops and the result mux live in the top level.
// TESTING
//  - ADD: p=5, q=7 -> r=12, ofw=0; p=1, q=0x7FFF_FFFF_FFFF_FFFF -> r=0x8000_0000_0000_0000, ofw=1.
//  - SUB: p=3, q=10 -> r=7, ofw=0; p=1, q=0x8000_0000_0000_0000 -> r=0x7FFF_FFFF_FFFF_FFFF, ofw=1.
//  - AND/XOR: p=0xF0F0, q=0xFF00 -> AND r=0xF000, XOR r=0x0FF0, ofw=0; select=3'b100 -> r=0.
//  - Flags (ALU_CC_EN): SUB p=q=9 with set_cc=1 -> zf=1, sf=0, of=0 after edge;
//    then set_cc=0 with new operands -> flags unchanged.
//  - Flags: SUB p=10, q=3 with set_cc=1 -> r=-7, zf=0, sf=1, of=0.
//  - Reset: rst_n low mid-run with flags set -> zf/sf/of = 0 before the next clk edge;
//    r still tracks the inputs.

Source files
------------

// File: rtl/y86_alu_pkg.sv
// Shared encodings for the Y86 execute-stage ALU: op selects, default width, flag indices.
package y86_alu_pkg;

    localparam int ALU_WIDTH = 64;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_XOR = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;

    // Bit positions inside the condition-code register.
    localparam int FLAG_ZF = 0;
    localparam int FLAG_SF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_W  = 3;

endpackage

// File: rtl/y86_alu_addsub.sv
// WIDTH-bit adder/subtractor: sum = q + p, or q - p (as q + ~p + 1) when sub is set.
module y86_alu_addsub #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] q,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             ofw
);

    logic [WIDTH-1:0] b;

    assign b   = sub ? ~p : p;
    assign sum = q + b + {{(WIDTH-1){1'b0}}, sub};

    // Overflow when both addends share a sign and the sum's sign differs from it.
    assign ofw = (q[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != q[WIDTH-1]);

endmodule

// File: rtl/y86_alu.sv
// Y86 execute ALU: combinational AND/XOR/ADD/SUB with an optional ZF/SF/OF register,
// built only when ALU_CC_EN is defined (otherwise the flags are tied to 0).
module y86_alu
    import y86_alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       select,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] q,
    input  logic             set_cc,
    output logic [WIDTH-1:0] r,
    output logic             ofw,
    output logic             zf,
    output logic             sf,
    output logic             of
);

    logic [WIDTH-1:0] as_sum;
    logic             as_ofw;

    y86_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .p   (p),
        .q   (q),
        .sub (select == ALU_SUB),
        .sum (as_sum),
        .ofw (as_ofw)
    );

    always_comb begin
        r   = '0;
        ofw = 1'b0;
        case (select)
            ALU_AND: r = p & q;
            ALU_XOR: r = p ^ q;
            ALU_ADD, ALU_SUB: begin
                r   = as_sum;
                ofw = as_ofw;
            end
            default: begin
                r   = '0;
                ofw = 1'b0;
            end
        endcase
    end

`ifdef ALU_CC_EN
    logic [FLAG_W-1:0] flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= '0;
        end else if (set_cc) begin
            flags[FLAG_ZF] <= (r == '0);
            flags[FLAG_SF] <= r[WIDTH-1];
            flags[FLAG_OF] <= ofw;
        end
    end

    assign zf = flags[FLAG_ZF];
    assign sf = flags[FLAG_SF];
    assign of = flags[FLAG_OF];
`else
    logic unused_cc_inputs;

    assign unused_cc_inputs = &{1'b0, clk, rst_n, set_cc};
    assign zf = 1'b0;
    assign sf = 1'b0;
    assign of = 1'b0;
`endif

endmodule

// File: tb/tb_y86_alu.sv
// Bench for y86_alu: directed vector table, flag/reset sequences, and random ops vs a wide-arithmetic model.
module tb_y86_alu;

    localparam int W = 64;
`ifdef ALU_CC_EN
    localparam bit CC_EN = 1'b1;
`else
    localparam bit CC_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic [2:0]   select;
    logic [W-1:0] p;
    logic [W-1:0] q;
    logic         set_cc;
    logic [W-1:0] r;
    logic         ofw;
    logic         zf;
    logic         sf;
    logic         of;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic         exp_zf;
    logic         exp_sf;
    logic         exp_of;

    y86_alu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .select (select),
        .p      (p),
        .q      (q),
        .set_cc (set_cc),
        .r      (r),
        .ofw    (ofw),
        .zf     (zf),
        .sf     (sf),
        .of     (of)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_flags(input string name);
        check1({name, ".zf"}, zf, exp_zf);
        check1({name, ".sf"}, sf, exp_sf);
        check1({name, ".of"}, of, exp_of);
    endtask

    // Reference model: signed arithmetic in 65 bits, overflow when the true value leaves the 64-bit range.
    function automatic void ref_alu(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] res, output logic o);
        logic signed [W:0] wide;
        logic signed [W:0] max_pos;
        logic signed [W:0] min_neg;
        max_pos = 65'sd9223372036854775807;
        min_neg = -65'sd9223372036854775808;
        res = '0;
        o   = 1'b0;
        case (sel)
            3'd0: res = a & b;
            3'd1: res = a ^ b;
            3'd2, 3'd3: begin
                if (sel == 3'd2) wide = $signed({b[W-1], b}) + $signed({a[W-1], a});
                else             wide = $signed({b[W-1], b}) - $signed({a[W-1], a});
                res = wide[W-1:0];
                o   = (wide > max_pos) || (wide < min_neg);
            end
            default: res = '0;
        endcase
    endfunction

    // driver: change inputs just after the falling edge, let them settle
    task automatic drive(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b, input logic cc);
        @(negedge clk);
        select = sel;
        p      = a;
        q      = b;
        set_cc = cc;
        #1;
    endtask

    // advance past a rising edge; model flag capture from the settled pre-edge result
    task automatic edge_update(input logic [W-1:0] res, input logic o);
        if (CC_EN && set_cc && rst_n) begin
            exp_zf = (res == '0);
            exp_sf = res[W-1];
            exp_of = o;
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string        name;
        logic [2:0]   sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_r;
        logic         exp_o;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [W-1:0] mr;
        logic         mo;
        logic [W-1:0] specials[6];

        vecs[0]  = '{"add_small",   3'b010, 64'd5, 64'd7, 64'd12, 1'b0};
        vecs[1]  = '{"add_ovf",     3'b010, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1};
        vecs[2]  = '{"sub_small",   3'b011, 64'd3, 64'd10, 64'd7, 1'b0};
        vecs[3]  = '{"sub_ovf",     3'b011, 64'd1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[4]  = '{"and",         3'b000, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0};
        vecs[5]  = '{"xor",         3'b001, 64'hF0F0, 64'hFF00, 64'h0FF0, 1'b0};
        vecs[6]  = '{"rsv_100",     3'b100, 64'hF0F0, 64'hFF00, 64'h0, 1'b0};
        vecs[7]  = '{"rsv_111",     3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 64'h0, 1'b0};
        vecs[8]  = '{"sub_neg",     3'b011, 64'd10, 64'd3, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0};
        vecs[9]  = '{"add_wrap0",   3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 1'b0};
        vecs[10] = '{"add_minmin",  3'b010, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1'b1};
        vecs[11] = '{"sub_min",     3'b011, 64'h8000_0000_0000_0000, 64'd0, 64'h8000_0000_0000_0000, 1'b1};

        specials[0] = 64'h0;
        specials[1] = 64'h1;
        specials[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        specials[3] = 64'h7FFF_FFFF_FFFF_FFFF;
        specials[4] = 64'h8000_0000_0000_0000;
        specials[5] = 64'h8000_0000_0000_0001;

        rst_n  = 1'b0;
        select = 3'b000;
        p      = '0;
        q      = '0;
        set_cc = 1'b0;
        exp_zf = 1'b0;
        exp_sf = 1'b0;
        exp_of = 1'b0;

        #2;
        check_flags("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // directed vectors
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].sel, vecs[i].a, vecs[i].b, 1'b0);
            check({vecs[i].name, ".r"}, r, vecs[i].exp_r);
            check1({vecs[i].name, ".ofw"}, ofw, vecs[i].exp_o);
        end
        edge_update('0, 1'b0);
        check_flags("hold_after_vectors");

        // flag capture and hold
        drive(3'b011, 64'd9, 64'd9, 1'b1);
        check("sub_eq.r", r, 64'd0);
        edge_update(64'd0, 1'b0);
        check1("sub_eq.zf", zf, CC_EN);
        check1("sub_eq.sf", sf, 1'b0);
        check1("sub_eq.of", of, 1'b0);

        drive(3'b011, 64'd10, 64'd3, 1'b0);
        edge_update(64'hFFFF_FFFF_FFFF_FFF9, 1'b0);
        check1("hold.zf", zf, CC_EN);
        check1("hold.sf", sf, 1'b0);

        drive(3'b011, 64'd10, 64'd3, 1'b1);
        check("sub_neg2.r", r, 64'hFFFF_FFFF_FFFF_FFF9);
        edge_update(64'hFFFF_FFFF_FFFF_FFF9, 1'b0);
        check1("sub_neg2.zf", zf, 1'b0);
        check1("sub_neg2.sf", sf, CC_EN);
        check1("sub_neg2.of", of, 1'b0);

        drive(3'b011, 64'd1, 64'h8000_0000_0000_0000, 1'b1);
        edge_update(64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        check1("sub_ovf_cc.of", of, CC_EN);
        check1("sub_ovf_cc.sf", sf, 1'b0);

        // async reset mid-cycle, then release
        drive(3'b011, 64'd10, 64'd3, 1'b1);
        edge_update(64'hFFFF_FFFF_FFFF_FFF9, 1'b0);
        @(negedge clk);
        #1;
        rst_n  = 1'b0;
        exp_zf = 1'b0;
        exp_sf = 1'b0;
        exp_of = 1'b0;
        #1;
        check_flags("async_rst");
        select = 3'b010;
        p      = 64'd5;
        q      = 64'd7;
        #1;
        check("rst_r_tracks", r, 64'd12);
        edge_update(64'd12, 1'b0);
        check_flags("rst_ignores_cc");
        @(negedge clk);
        rst_n  = 1'b1;
        set_cc = 1'b0;
        edge_update(64'd12, 1'b0);
        check_flags("rst_release");
        drive(3'b011, 64'd9, 64'd9, 1'b1);
        edge_update(64'd0, 1'b0);
        check_flags("post_rst_cc");

        // random stimulus against the model
        for (int i = 0; i < 300; i++) begin
            logic [2:0]   s;
            logic [W-1:0] a;
            logic [W-1:0] b;
            s = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : {$urandom, $urandom};
            b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : {$urandom, $urandom};
            ref_alu(s, a, b, mr, mo);
            exp_q.push_back(mr);
            drive(s, a, b, 1'($urandom_range(0, 1)));
            check("rand.r", r, exp_q.pop_front());
            check1("rand.ofw", ofw, mo);
            edge_update(mr, mo);
            check_flags("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
